// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel
// Description : NUM_CH-channel PWM generator sharing one period counter,
//               edge- or center-aligned, with double-buffered duty values.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter int WIDTH  = 10,
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic                      load,
    input  logic [NUM_CH*WIDTH-1:0]   duty,
    output logic [NUM_CH-1:0]         PWM_sig,
    output logic                      period_start
);

    localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [WIDTH-1:0]          cnt_q,      cnt_d;
    dir_t                      dir_q,      dir_d;
    logic                      mode_act_q, mode_act_d;
    logic [NUM_CH*WIDTH-1:0]   duty_sh_q,  duty_sh_d;
    logic [NUM_CH*WIDTH-1:0]   duty_act_q, duty_act_d;
    logic [NUM_CH-1:0]         pwm_q,      pwm_d;
    logic                      pstart_q,   pstart_d;
    logic                      w_boundary;

    // Period boundary: the only point where new duties and mode are adopted.
    assign w_boundary = !en
                      || (!mode_act_q && (cnt_q == c_MAX))
                      || (mode_act_q && (dir_q == DIR_DOWN) && (cnt_q == c_ONE));

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            cnt_d = c_ZERO;
            dir_d = DIR_UP;
        end else if (!mode_act_q) begin
            cnt_d = cnt_q + c_ONE;
            dir_d = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == c_MAX) begin
                cnt_d = c_MAX - c_ONE;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + c_ONE;
            end
        end else begin
            if (cnt_q == c_ONE) begin
                cnt_d = c_ZERO;
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - c_ONE;
            end
        end
    end

    // Active takes the old shadow even when a load coincides with the boundary.
    always_comb begin
        duty_sh_d  = load       ? duty      : duty_sh_q;
        duty_act_d = w_boundary ? duty_sh_q : duty_act_q;
        mode_act_d = w_boundary ? mode      : mode_act_q;
        pstart_d   = en && (cnt_q == c_ZERO);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign pwm_d[gi] = en && (cnt_q < duty_act_q[gi*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= c_ZERO;
            dir_q      <= DIR_UP;
            mode_act_q <= 1'b0;
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= '0;
            pstart_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            mode_act_q <= mode_act_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
            pstart_q   <= pstart_d;
        end
    end

    assign PWM_sig      = pwm_q;
    assign period_start = pstart_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_channel
// Description : Directed self-checking bench for pwm_multi_channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel;

    localparam int W = 10;
    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic             load;
    logic [N*W-1:0]   duty;
    logic [N-1:0]     PWM_sig;
    logic             period_start;

    int n_tests;
    int n_fail;

    int         m_len;
    int         m_hi [N];
    int         m_hi0_a;
    logic [N-1:0] m_first;
    logic [N-1:0] m_last;

    pwm_multi_channel #(.WIDTH(W), .NUM_CH(N)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .load         (load),
        .duty         (duty),
        .PWM_sig      (PWM_sig),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic wait_pstart();
        int k = 0;
        while (!period_start && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!period_start) check("pstart_timeout", 0, 1);
    endtask

    // Measures one period starting at a period_start sample; optional load / mode change mid-period.
    task automatic measure(input int load_at, input logic [N*W-1:0] load_val,
                           input int mode_at, input logic mode_val);
        int i;
        wait_pstart();
        m_hi0_a = 0;
        for (int c = 0; c < N; c++) m_hi[c] = 0;
        m_first = PWM_sig;
        m_last  = '0;
        i = 0;
        do begin
            for (int c = 0; c < N; c++) if (PWM_sig[c]) m_hi[c]++;
            if (i < 1024 && PWM_sig[0]) m_hi0_a++;
            m_last = PWM_sig;
            load = 1'b0;
            if (i == load_at) begin
                duty = load_val;
                load = 1'b1;
            end
            if (i == mode_at) mode = mode_val;
            i++;
            @(negedge clk);
        end while (!period_start && i < 5000);
        load  = 1'b0;
        m_len = i;
    endtask

    task automatic check_period(input string tag, input int len,
                                input int h0, input int h1, input int h2, input int h3);
        check({tag, "_len"}, m_len, len);
        check({tag, "_hi0"}, m_hi[0], h0);
        check({tag, "_hi1"}, m_hi[1], h1);
        check({tag, "_hi2"}, m_hi[2], h2);
        check({tag, "_hi3"}, m_hi[3], h3);
    endtask

    initial begin
        int cnt_hi;
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        load = 1'b0;
        duty = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(PWM_sig), 0);
        check("reset_pstart", int'(period_start), 0);
        rst = 1'b0;

        // Edge mode: ch0=48, ch1=768, ch2=0, ch3=1023
        @(negedge clk);
        duty = pack(10'd48, 10'd768, 10'd0, 10'd1023);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("first_pstart", int'(period_start), 1);

        measure(-1, '0, -1, 1'b0);
        check_period("edge_p1", 1024, 48, 768, 0, 1023);
        check("edge_p1_first", int'(m_first), 4'b1011);
        check("edge_p1_last", int'(m_last), 4'b0000);
        measure(-1, '0, -1, 1'b0);
        check_period("edge_p2", 1024, 48, 768, 0, 1023);

        // Load mid-period: current period keeps 48
        measure(499, pack(10'd100, 10'd768, 10'd0, 10'd1023), -1, 1'b0);
        check_period("glitch_cur", 1024, 48, 768, 0, 1023);
        // Load coincident with boundary (cnt == MAX)
        measure(1022, pack(10'd200, 10'd768, 10'd0, 10'd1023), -1, 1'b0);
        check("glitch_next_hi0", m_hi[0], 100);
        measure(-1, '0, -1, 1'b0);
        check("simul_p1_hi0", m_hi[0], 100);
        measure(-1, '0, -1, 1'b0);
        check("simul_p2_hi0", m_hi[0], 200);
        check("simul_p2_len", m_len, 1024);

        // Asynchronous reset mid-run while outputs are high
        check("pre_rst_pwm", int'(PWM_sig), 4'b1011);
        rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(PWM_sig), 0);
        check("async_rst_pstart", int'(period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_restart_pstart", int'(period_start), 1);
        cnt_hi = 0;
        for (int k = 0; k < 2100; k++) begin
            if (PWM_sig != '0) cnt_hi++;
            @(negedge clk);
        end
        check("post_rst_pwm_low", cnt_hi, 0);

        // Center mode: ch0=256, ch1=1023, ch2=0, ch3=1
        en   = 1'b0;
        mode = 1'b1;
        duty = pack(10'd256, 10'd1023, 10'd0, 10'd1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("center_first_pstart", int'(period_start), 1);
        measure(-1, '0, 1000, 1'b0);
        check_period("center_p1", 2046, 511, 2045, 0, 1);
        check("center_p1_half0", m_hi0_a, 256);
        check("center_p1_first", int'(m_first), 4'b1011);
        check("center_p1_last", int'(m_last), 4'b0011);

        // Mode switched to edge mid-period: applies from here
        measure(-1, '0, -1, 1'b0);
        check_period("c2e_p1", 1024, 256, 1023, 0, 1);
        check("c2e_p1_first", int'(m_first), 4'b1011);

        // Enable falling then rising
        en = 1'b0;
        @(negedge clk);
        check("en_fall_pwm", int'(PWM_sig), 0);
        check("en_fall_pstart", int'(period_start), 0);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_rise_pstart", int'(period_start), 1);
        check("en_rise_pwm", int'(PWM_sig), 4'b1011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
